// File: rtl/wb_dsp_bus_arbiter.sv
// wb_dsp_bus_arbiter: two-master Wishbone B3 arbiter (DSP m0, host m1), cycle-granular round-robin
// define WB_DSP_ARB_TIMEOUT_EN to add the stalled-slave watchdog (parameter timeout_cycles)
module wb_dsp_bus_arbiter #(
   parameter int aw = 32,
   parameter int dw = 32
`ifdef WB_DSP_ARB_TIMEOUT_EN
   ,parameter int timeout_cycles = 255
`endif
) (
   input  logic          wb_clk,
   input  logic          wb_rst,
   input  logic [aw-1:0] m0_adr_i,
   input  logic [dw-1:0] m0_dat_i,
   input  logic [3:0]    m0_sel_i,
   input  logic          m0_we_i,
   input  logic          m0_cyc_i,
   input  logic          m0_stb_i,
   input  logic [2:0]    m0_cti_i,
   input  logic [1:0]    m0_bte_i,
   output logic [dw-1:0] m0_dat_o,
   output logic          m0_ack_o,
   output logic          m0_err_o,
   output logic          m0_rty_o,
   input  logic [aw-1:0] m1_adr_i,
   input  logic [dw-1:0] m1_dat_i,
   input  logic [3:0]    m1_sel_i,
   input  logic          m1_we_i,
   input  logic          m1_cyc_i,
   input  logic          m1_stb_i,
   input  logic [2:0]    m1_cti_i,
   input  logic [1:0]    m1_bte_i,
   output logic [dw-1:0] m1_dat_o,
   output logic          m1_ack_o,
   output logic          m1_err_o,
   output logic          m1_rty_o,
   output logic [aw-1:0] s_adr_o,
   output logic [dw-1:0] s_dat_o,
   output logic [3:0]    s_sel_o,
   output logic          s_we_o,
   output logic          s_cyc_o,
   output logic          s_stb_o,
   output logic [2:0]    s_cti_o,
   output logic [1:0]    s_bte_o,
   input  logic [dw-1:0] s_dat_i,
   input  logic          s_ack_i,
   input  logic          s_err_i,
   input  logic          s_rty_i,
   output logic [1:0]    grant
);
   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
   state_t state, state_nx;
   logic last_owner, g0, g1, stb_raw, term, tmo;
   always_ff @(posedge wb_clk)
      if (wb_rst) begin
         state      <= IDLE;
         last_owner <= 1'b1;
      end else begin
         state <= state_nx;
         if (state != IDLE && state_nx == IDLE) last_owner <= state == GRANT1;
      end
   // owners always pass through IDLE; contention goes to whoever did not own last
   always_comb
      state_nx = state == GRANT0 ? (m0_cyc_i ? GRANT0 : IDLE) :
                 state == GRANT1 ? (m1_cyc_i ? GRANT1 : IDLE) :
                 m0_cyc_i && m1_cyc_i ? (last_owner ? GRANT0 : GRANT1) :
                 m0_cyc_i ? GRANT0 : m1_cyc_i ? GRANT1 : IDLE;
   always_comb begin
      g0    = state == GRANT0;
      g1    = state == GRANT1;
      grant = {g1, g0};
   end
   assign s_adr_o = g0 ? m0_adr_i : g1 ? m1_adr_i : '0;
   assign s_dat_o = g0 ? m0_dat_i : g1 ? m1_dat_i : '0;
   assign s_sel_o = g0 ? m0_sel_i : g1 ? m1_sel_i : '0;
   assign s_we_o  = g0 ? m0_we_i  : g1 ? m1_we_i  : 1'b0;
   assign s_cyc_o = g0 ? m0_cyc_i : g1 ? m1_cyc_i : 1'b0;
   assign s_cti_o = g0 ? m0_cti_i : g1 ? m1_cti_i : '0;
   assign s_bte_o = g0 ? m0_bte_i : g1 ? m1_bte_i : '0;
   assign stb_raw = g0 ? m0_stb_i : g1 ? m1_stb_i : 1'b0;
   assign s_stb_o = stb_raw & ~tmo;
   assign term    = s_ack_i | s_err_i | s_rty_i;
`ifdef WB_DSP_ARB_TIMEOUT_EN
   localparam int tw = $clog2(timeout_cycles + 1) > 8 ? $clog2(timeout_cycles + 1) : 8;
   logic [tw-1:0] cnt;
   assign tmo = cnt == tw'(timeout_cycles);
   // held at zero while idle so every new grant starts a fresh count
   always_ff @(posedge wb_clk)
      if (wb_rst || state == IDLE || term || tmo) cnt <= '0;
      else if (stb_raw) cnt <= cnt + tw'(1);
`else
   assign tmo = 1'b0;
`endif
   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;
   assign m0_ack_o = g0 & s_ack_i;
   assign m1_ack_o = g1 & s_ack_i;
   assign m0_err_o = g0 & (s_err_i | tmo);
   assign m1_err_o = g1 & (s_err_i | tmo);
   assign m0_rty_o = g0 & s_rty_i;
   assign m1_rty_o = g1 & s_rty_i;
endmodule

// File: tb/tb_wb_dsp_bus_arbiter.sv
// tb_wb_dsp_bus_arbiter: directed checks of grant sequencing, muxing, termination gating, reset and watchdog
module tb_wb_dsp_bus_arbiter;
   logic        wb_clk = 1'b0, wb_rst;
   logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i, s_dat_i;
   logic [3:0]  m0_sel_i, m1_sel_i;
   logic        m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
   logic [2:0]  m0_cti_i, m1_cti_i;
   logic [1:0]  m0_bte_i, m1_bte_i;
   logic        s_ack_i, s_err_i, s_rty_i;
   logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
   logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
   logic [3:0]  s_sel_o;
   logic        s_we_o, s_cyc_o, s_stb_o;
   logic [2:0]  s_cti_o;
   logic [1:0]  s_bte_o, grant;
   int checks = 0, errors = 0;
   always #5 wb_clk = ~wb_clk;
`ifdef WB_DSP_ARB_TIMEOUT_EN
   wb_dsp_bus_arbiter #(.aw(32), .dw(32), .timeout_cycles(8)) dut (
`else
   wb_dsp_bus_arbiter #(.aw(32), .dw(32)) dut (
`endif
      .wb_clk(wb_clk), .wb_rst(wb_rst),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i),
      .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i),
      .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
      .grant(grant)
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask
   task automatic nxt;
      @(posedge wb_clk);
      #1;
   endtask
   task automatic clear_inputs;
      {m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i, m0_cti_i, m0_bte_i} = '0;
      {m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i, m1_cti_i, m1_bte_i} = '0;
      {s_dat_i, s_ack_i, s_err_i, s_rty_i} = '0;
   endtask
   task automatic rst_dut;
      clear_inputs();
      wb_rst = 1'b1;
      nxt();
      nxt();
      wb_rst = 1'b0;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      logic [31:0] d6[4];
      logic [3:0]  sl6[4];
      int errs;
      d6  = '{32'h11111111, 32'hA5A5A5A5, 32'h0000BEEF, 32'hCAFEF00D};
      sl6 = '{4'hF, 4'h3, 4'hC, 4'h1};
      // reset holds the bus idle and masks terminations even with requests and slave strobes present
      clear_inputs();
      wb_rst = 1'b1;
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h55;
      s_ack_i = 1'b1; s_err_i = 1'b1; s_rty_i = 1'b1;
      nxt(); nxt(); #1;
      chk("rst_grant", grant, 0);
      chk("rst_s_cyc", s_cyc_o, 0);
      chk("rst_s_stb", s_stb_o, 0);
      chk("rst_s_adr", s_adr_o, 0);
      chk("rst_m0_ack", m0_ack_o, 0);
      chk("rst_m0_err", m0_err_o, 0);
      chk("rst_m1_rty", m1_rty_o, 0);
      // simultaneous request after reset: m0 first, then m1 after one idle cycle
      rst_dut();
      nxt();
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h10;
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h20;
      #1;
      chk("t2_req_idle", grant, 0);
      nxt(); #1;
      chk("t2_grant_m0", grant, 2'b01);
      chk("t2_adr_m0", s_adr_o, 32'h10);
      nxt();
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      #1;
      chk("t2_cyc_drop", s_cyc_o, 0);
      nxt(); #1;
      chk("t2_idle_gap", grant, 0);
      nxt(); #1;
      chk("t2_grant_m1", grant, 2'b10);
      chk("t2_adr_m1", s_adr_o, 32'h20);
      nxt();
      m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
      nxt(); #1;
      chk("t2_idle2", grant, 0);
      m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
      nxt(); #1;
      chk("t2_rr_m0", grant, 2'b01);
      clear_inputs();
      nxt(); nxt();
      // single m0 read, slave acks two cycles after strobe
      nxt();
      m0_adr_i = 32'h100; m0_sel_i = 4'hF; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
      #1;
      chk("t1_idle_stb", s_stb_o, 0);
      nxt(); #1;
      chk("t1_grant", grant, 2'b01);
      chk("t1_stb", s_stb_o, 1);
      chk("t1_adr", s_adr_o, 32'h100);
      nxt(); #1;
      chk("t1_wait_ack", m0_ack_o, 0);
      nxt();
      s_ack_i = 1'b1; s_dat_i = 32'hDEADBEEF;
      #1;
      chk("t1_m0_ack", m0_ack_o, 1);
      chk("t1_m0_dat", m0_dat_o, 32'hDEADBEEF);
      chk("t1_m1_dat", m1_dat_o, 32'hDEADBEEF);
      chk("t1_m1_ack", m1_ack_o, 0);
      nxt();
      s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      #1;
      chk("t1_release_cyc", s_cyc_o, 0);
      nxt(); #1;
      chk("t1_idle", grant, 0);
      // m0 4-beat burst with m1 requesting mid-burst
      nxt();
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_cti_i = 3'b010; m0_adr_i = 32'h200; m0_bte_i = 2'b00;
      m1_adr_i = 32'h300;
      nxt();
      s_ack_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            nxt();
            m0_adr_i = 32'h200 + 32'(i * 4);
            m0_cti_i = i == 3 ? 3'b111 : 3'b010;
            #1;
         end
         chk($sformatf("t3_grant_b%0d", i), grant, 2'b01);
         chk($sformatf("t3_adr_b%0d", i), s_adr_o, 32'h200 + 32'(i * 4));
         chk($sformatf("t3_cti_b%0d", i), s_cti_o, i == 3 ? 3'b111 : 3'b010);
         chk($sformatf("t3_m0_ack_b%0d", i), m0_ack_o, 1);
         chk($sformatf("t3_m1_ack_b%0d", i), m1_ack_o, 0);
      end
      nxt();
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_cti_i = 3'b000; s_ack_i = 1'b0;
      #1;
      chk("t3_hold_m0", grant, 2'b01);
      nxt(); #1;
      chk("t3_idle", grant, 0);
      nxt(); #1;
      chk("t3_grant_m1", grant, 2'b10);
      chk("t3_adr_m1", s_adr_o, 32'h300);
      // reset while m1 owns with a strobe pending, m0 waiting
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h400;
      wb_rst = 1'b1;
      nxt(); #1;
      chk("t4_rst_grant", grant, 0);
      chk("t4_rst_cyc", s_cyc_o, 0);
      wb_rst = 1'b0;
      nxt(); #1;
      chk("t4_grant_m0", grant, 2'b01);
      chk("t4_adr_m0", s_adr_o, 32'h400);
      clear_inputs();
      nxt(); nxt();
      // m1 write to a slave that never answers
      nxt();
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_adr_i = 32'h500; m1_dat_i = 32'h1234; m1_sel_i = 4'h3;
      nxt(); #1;
      chk("t5_grant", grant, 2'b10);
`ifdef WB_DSP_ARB_TIMEOUT_EN
      for (int i = 1; i < 8; i++) begin
         nxt(); #1;
         chk($sformatf("t5_no_err_%0d", i), m1_err_o, 0);
      end
      nxt(); #1;
      chk("t5_err_pulse", m1_err_o, 1);
      chk("t5_stb_forced", s_stb_o, 0);
      chk("t5_m0_err", m0_err_o, 0);
      nxt(); #1;
      chk("t5_err_single", m1_err_o, 0);
      chk("t5_stb_back", s_stb_o, 1);
      chk("t5_grant_kept", grant, 2'b10);
`else
      errs = 0;
      repeat (100) begin
         nxt(); #1;
         errs += int'(m1_err_o);
      end
      chk("t5_no_err", errs, 0);
      chk("t5_grant_kept", grant, 2'b10);
`endif
      nxt();
      clear_inputs();
      nxt(); nxt();
      // back-to-back m1 single writes inside one held cycle
      nxt();
      m1_cyc_i = 1'b1; m1_we_i = 1'b1;
      nxt(); #1;
      chk("t6_grant", grant, 2'b10);
      for (int i = 0; i < 4; i++) begin
         nxt();
         m1_stb_i = 1'b1; m1_adr_i = 32'h600 + 32'(i * 4); m1_dat_i = d6[i]; m1_sel_i = sl6[i]; s_ack_i = 1'b1;
         #1;
         chk($sformatf("t6_adr_%0d", i), s_adr_o, 32'h600 + 32'(i * 4));
         chk($sformatf("t6_dat_%0d", i), s_dat_o, d6[i]);
         chk($sformatf("t6_sel_%0d", i), s_sel_o, sl6[i]);
         chk($sformatf("t6_we_%0d", i), s_we_o, 1);
         chk($sformatf("t6_ack_%0d", i), m1_ack_o, 1);
         chk($sformatf("t6_grant_%0d", i), grant, 2'b10);
         nxt();
         m1_stb_i = 1'b0; s_ack_i = 1'b0;
         #1;
         chk($sformatf("t6_gap_stb_%0d", i), s_stb_o, 0);
         chk($sformatf("t6_gap_grant_%0d", i), grant, 2'b10);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
